// File: rtl/rifl_pkg.sv
// Shared encodings and state type for the TX flow-control path.
package rifl_pkg;

  localparam logic [1:0]  SYNC_CTRL   = 2'b10;
  localparam logic [1:0]  SYNC_DATA   = 2'b01;

  localparam logic [15:0] IDLE_KEY    = 16'h0001;
  localparam logic [15:0] PAUSE_KEY   = 16'h0010;
  localparam logic [15:0] RETRANS_KEY = 16'h1000;
  localparam logic [15:0] DATA_KEY    = 16'h0000;

  typedef enum logic [1:0] {
    NORMAL,
    PAUSE,
    RETRANS
  } tx_ctrl_state_t;

  // Build an 18-bit control-frame header from a key.
  function automatic logic [17:0] ctrl_code(input logic [15:0] key);
    return {SYNC_CTRL, key};
  endfunction

endpackage

// File: rtl/frame_burst_counter.sv
// Saturating frame counter: clears on clr_i, steps on inc_i, stops at term_i.
// tc_o flags that the count has reached the terminal value.
module frame_burst_counter #(
  parameter int W       = 4,
  parameter bit RST_SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear has priority, increment saturates at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < term_i)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register; reset either to zero or straight to the terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_SAT ? term_i : '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == term_i);

endmodule

// File: rtl/tx_controller.sv
// Transmit-side flow control: picks data / IDLE / PAUSE / RETRANS headers per
// frame request, gates user data and issues the replay-rewind pulse.
module tx_controller
  import rifl_pkg::*;
#(
  parameter int PAUSE_REPEAT   = 12,
  parameter int RETRANS_REPEAT = 12,
  parameter int REGULAR_GAP    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_up,
  input  logic        frame_req,
  input  logic        data_avail,
  input  logic        local_pause,
  input  logic        local_retrans,
  input  logic        pause_req,
  input  logic        retrans_req,
  output logic [17:0] code,
  output logic        data_en,
  output logic        replay_rewind
);

  localparam int BURST_MAX = (PAUSE_REPEAT > RETRANS_REPEAT) ? PAUSE_REPEAT : RETRANS_REPEAT;
  localparam int BURST_W   = $clog2(BURST_MAX + 1);
  localparam int GAP_W     = $clog2(REGULAR_GAP + 1);

  tx_ctrl_state_t state_q, state_d;
  logic [17:0]    code_q, code_d;
  logic           data_en_q, data_en_d;
  logic           pend_q, pend_d;
  logic           rtr_q;
  logic           rewind_q;

  logic               link_rst;
  logic               eval_normal;
  logic               burst_inc, burst_clr, burst_tc;
  logic               gap_inc, gap_clr, gap_tc;
  logic [BURST_W-1:0] burst_term;

  // Link down is treated exactly like reset.
  assign link_rst   = rst | ~tx_up;
  // The burst counter's terminal value follows the burst being sent.
  assign burst_term = (state_q == PAUSE) ? BURST_W'(PAUSE_REPEAT) : BURST_W'(RETRANS_REPEAT);

  frame_burst_counter #(.W(BURST_W), .RST_SAT(1'b0)) u_burst_cnt (
    .clk    (clk),
    .rst    (link_rst),
    .clr_i  (burst_clr),
    .inc_i  (burst_inc),
    .term_i (burst_term),
    .tc_o   (burst_tc)
  );

  // Gap counter starts saturated so a replay may begin right after link-up.
  frame_burst_counter #(.W(GAP_W), .RST_SAT(1'b1)) u_gap_cnt (
    .clk    (clk),
    .rst    (link_rst),
    .clr_i  (gap_clr),
    .inc_i  (gap_inc),
    .term_i (GAP_W'(REGULAR_GAP)),
    .tc_o   (gap_tc)
  );

  // Next-state and frame selection, evaluated only on a frame request.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    data_en_d   = data_en_q;
    pend_d      = pend_q | (local_retrans & (state_q != RETRANS));
    eval_normal = 1'b0;
    burst_inc   = 1'b0;
    burst_clr   = 1'b0;
    gap_inc     = 1'b0;
    gap_clr     = 1'b0;

    if (frame_req) begin
      case (state_q)
        RETRANS: begin
          if (burst_tc) begin
            eval_normal = 1'b1;
          end else begin
            code_d    = ctrl_code(RETRANS_KEY);
            data_en_d = 1'b0;
            burst_inc = 1'b1;
            gap_clr   = 1'b1;
          end
        end
        PAUSE: begin
          if (burst_tc && !local_pause) begin
            eval_normal = 1'b1;
          end else begin
            code_d    = ctrl_code(PAUSE_KEY);
            data_en_d = 1'b0;
            burst_inc = 1'b1;
            gap_clr   = 1'b1;
          end
        end
        default: eval_normal = 1'b1;
      endcase

      if (eval_normal) begin
        if (pend_q && gap_tc) begin
          state_d   = RETRANS;
          code_d    = ctrl_code(RETRANS_KEY);
          data_en_d = 1'b0;
          pend_d    = local_retrans;
          burst_inc = 1'b1;
          gap_clr   = 1'b1;
        end else if (local_pause) begin
          state_d   = PAUSE;
          code_d    = ctrl_code(PAUSE_KEY);
          data_en_d = 1'b0;
          burst_inc = 1'b1;
          gap_clr   = 1'b1;
        end else begin
          state_d   = NORMAL;
          burst_clr = 1'b1;
          gap_inc   = 1'b1;
          if (data_avail && !pause_req && !retrans_req) begin
            code_d    = {SYNC_DATA, DATA_KEY};
            data_en_d = 1'b1;
          end else begin
            code_d    = ctrl_code(IDLE_KEY);
            data_en_d = 1'b0;
          end
        end
      end
    end
  end

  // State, held frame header and pending-replay flag.
  always_ff @(posedge clk) begin
    if (link_rst) begin
      state_q   <= NORMAL;
      code_q    <= ctrl_code(IDLE_KEY);
      data_en_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      data_en_q <= data_en_d;
      pend_q    <= pend_d;
    end
  end

  // Rising-edge detector on retrans_req producing the one-cycle rewind pulse.
  always_ff @(posedge clk) begin
    if (link_rst) begin
      rtr_q    <= 1'b0;
      rewind_q <= 1'b0;
    end else begin
      rtr_q    <= retrans_req;
      rewind_q <= retrans_req & ~rtr_q;
    end
  end

  assign code          = code_q;
  assign data_en       = data_en_q;
  assign replay_rewind = rewind_q;

endmodule

// File: tb/tb_tx_controller.sv
// Scoreboard bench for tx_controller: the driver queues the expected header
// for every frame request, the monitor checks it when the frame is presented.
module tb_tx_controller;

  localparam logic [17:0] C_IDLE  = 18'h20001;
  localparam logic [17:0] C_DATA  = 18'h10000;
  localparam logic [17:0] C_PAUSE = 18'h20010;
  localparam logic [17:0] C_RTR   = 18'h21000;

  typedef struct packed {
    logic [17:0] code;
    logic        den;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_up = 1'b0;
  logic        frame_req = 1'b0;
  logic        data_avail = 1'b0;
  logic        local_pause = 1'b0;
  logic        local_retrans = 1'b0;
  logic        pause_req = 1'b0;
  logic        retrans_req = 1'b0;
  logic [17:0] code;
  logic        data_en;
  logic        replay_rewind;

  exp_t exp_q[$];
  exp_t e;
  logic fr_seen = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   frame_idx = 0;

  always #5 clk = ~clk;

  tx_controller dut (
    .clk           (clk),
    .rst           (rst),
    .tx_up         (tx_up),
    .frame_req     (frame_req),
    .data_avail    (data_avail),
    .local_pause   (local_pause),
    .local_retrans (local_retrans),
    .pause_req     (pause_req),
    .retrans_req   (retrans_req),
    .code          (code),
    .data_en       (data_en),
    .replay_rewind (replay_rewind)
  );

  // A frame is presented on the edge after its request.
  always @(posedge clk) fr_seen <= frame_req;

  // Monitor: pop the oldest expectation and compare with the presented frame.
  always @(negedge clk) begin
    if (fr_seen) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected[%0d]: got code=%h data_en=%b, no frame expected",
                 frame_idx, code, data_en);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (code !== e.code || data_en !== e.den) begin
          errors++;
          $display("FAIL frame[%0d]: got code=%h data_en=%b, expected code=%h data_en=%b",
                   frame_idx, code, data_en, e.code, e.den);
        end
      end
      frame_idx++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [17:0] c, input logic de);
    @(negedge clk);
    frame_req = 1'b1;
    exp_q.push_back('{code: c, den: de});
    @(negedge clk);
    frame_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendn(input int n, input logic [17:0] c, input logic de);
    for (int i = 0; i < n; i++) send(c, de);
  endtask

  task automatic pulse_retrans();
    @(negedge clk);
    local_retrans = 1'b1;
    @(negedge clk);
    local_retrans = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_code", 32'(code), 32'(C_IDLE));
    check("rst_data_en", 32'(data_en), 32'd0);
    check("rst_rewind", 32'(replay_rewind), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("linkdown_code", 32'(code), 32'(C_IDLE));
    tx_up = 1'b1;
    data_avail = 1'b1;

    // 1: plain data
    sendn(5, C_DATA, 1'b1);

    // 2: replay burst, gap, second request during gap waits for a full gap
    pulse_retrans();
    sendn(12, C_RTR, 1'b0);
    sendn(4, C_DATA, 1'b1);
    pulse_retrans();
    sendn(16, C_DATA, 1'b1);
    sendn(12, C_RTR, 1'b0);
    sendn(21, C_DATA, 1'b1);

    // 3: long pause, then short pause stretched to minimum burst
    local_pause = 1'b1;
    sendn(30, C_PAUSE, 1'b0);
    local_pause = 1'b0;
    send(C_DATA, 1'b1);
    local_pause = 1'b1;
    sendn(3, C_PAUSE, 1'b0);
    local_pause = 1'b0;
    sendn(9, C_PAUSE, 1'b0);
    send(C_DATA, 1'b1);

    // 4: far-end replay request
    @(negedge clk);
    retrans_req = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (replay_rewind) n++;
    end
    check("rewind_pulses", 32'(n), 32'd1);
    sendn(3, C_IDLE, 1'b0);
    retrans_req = 1'b0;
    @(negedge clk);
    check("rewind_on_fall", 32'(replay_rewind), 32'd0);
    send(C_DATA, 1'b1);

    // 5: far-end pause gates data but not local pause
    pause_req = 1'b1;
    sendn(3, C_IDLE, 1'b0);
    local_pause = 1'b1;
    send(C_PAUSE, 1'b0);
    local_pause = 1'b0;
    sendn(11, C_PAUSE, 1'b0);
    send(C_IDLE, 1'b0);
    pause_req = 1'b0;
    send(C_DATA, 1'b1);

    // 6: link drop mid replay burst
    sendn(18, C_DATA, 1'b1);
    pulse_retrans();
    sendn(4, C_RTR, 1'b0);
    @(negedge clk);
    frame_req = 1'b1;
    tx_up = 1'b0;
    exp_q.push_back('{code: C_IDLE, den: 1'b0});
    @(negedge clk);
    frame_req = 1'b0;
    check("linkdrop_code", 32'(code), 32'(C_IDLE));
    check("linkdrop_data_en", 32'(data_en), 32'd0);
    @(negedge clk);
    tx_up = 1'b1;
    sendn(25, C_DATA, 1'b1);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_controller.md
Name: tx_controller

Overview:
- Transmit-side flow-control stage. It is the TX-side consumer of the RX controller's pause_req/retrans_req outputs, and it produces the 18-bit per-frame header code that the far-end RX controller decodes.
- Each outgoing frame is one of: data, IDLE, PAUSE burst or RETRANS burst.
- The block gates local user-data transmission and issues a replay-rewind to the retransmit buffer.
- It sits between the local RX controller / RX buffer monitor and the TX gearbox/scrambler.

Parameters:
- PAUSE_REPEAT, 12, minimum consecutive PAUSE frames per pause burst (must be ≥9 for far-end detection).
- RETRANS_REPEAT, 12, exact number of consecutive RETRANS frames per retrans burst (must be ≥9).
- REGULAR_GAP, 20, minimum consecutive regular (data/IDLE) frames after any control burst before another RETRANS burst may start (must be ≥17 so the far end clears its request).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- tx_up  in  1  link-up; when low, behaves as reset.
- frame_req  in  1  one-cycle pulse; the gearbox requests the next frame's header.
- data_avail  in  1  retransmit buffer holds a payload word ready to send.
- local_pause  in  1  level; local RX buffer almost full, far end must pause.
- local_retrans  in  1  pulse; local RX detected a CRC/sequence error, far end must replay.
- pause_req  in  1  from RX controller; far end asked us to pause.
- retrans_req  in  1  from RX controller; far end asked us to replay.
- code  out  18  frame header, [17:16] sync header, [15:0] key/payload tag.
- data_en  out  1  current frame carries user data; the buffer pops on frame_req & data_en.
- replay_rewind  out  1  one-cycle pulse; rewind the retransmit buffer read pointer to the oldest unacked entry.

Behaviour:
- Encodings:
  - Control: header 2'b10 with IDLE_KEY 16'h0001, PAUSE_KEY 16'h0010, RETRANS_KEY 16'h1000.
  - Data: header 2'b01, key field 16'h0000.
  - "Regular" frame = data frame or IDLE.
- Reset or tx_up low:
  - code = {2'b10, IDLE_KEY}, data_en = 0, replay_rewind = 0.
  - State NORMAL; all counters 0; retrans_pending = 0; gap counter saturated, so a RETRANS burst is allowed immediately after link-up.
- Latency and timing:
  - code and data_en update on the clock edge after frame_req, and are held until the next frame_req.
  - Between frame_req pulses, state and counters are frozen; local_retrans pulses are still latched.
- States:
  - NORMAL: emit a data frame if data_avail & ~pause_req & ~retrans_req, otherwise IDLE. Each frame increments the gap counter, saturating at REGULAR_GAP.
  - RETRANS: emit RETRANS_KEY. The burst counter counts to RETRANS_REPEAT; on the last frame go to NORMAL and clear the gap counter.
  - PAUSE: emit PAUSE_KEY. The burst counter saturates at PAUSE_REPEAT. Leave to NORMAL when the counter equals PAUSE_REPEAT and local_pause = 0, then clear the gap counter.
- Transition evaluation (NORMAL, at frame_req), in priority order:
  1. retrans_pending & gap complete → RETRANS; clear retrans_pending.
  2. local_pause → PAUSE.
  3. Otherwise stay in NORMAL.
- Interactions:
  - A pause burst in progress is never interrupted by retrans_pending; RETRANS is taken only after pause ends and the gap completes.
- local_retrans latching:
  - In NORMAL or PAUSE: set retrans_pending.
  - In RETRANS: dropped; the running burst covers it.
  - A pulse coinciding with frame_req is latched and evaluated at the next frame_req.
- replay_rewind:
  - One-cycle pulse on the rising edge of retrans_req; the edge detector register resets to 0.
  - While retrans_req or pause_req is high, data_en = 0 in every state.
  - Data resumes on the first frame_req after both are low.
- Simultaneous events:
  - frame_req with tx_up falling → the reset values win.
  - data_en is only ever 1 in NORMAL.
- Counter widths: $clog2(max parameter + 1); no wrap-around anywhere (saturating).

Decomposition:
- Package rifl_pkg holds:
  - SYNC_CTRL 2'b10 and SYNC_DATA 2'b01;
  - IDLE_KEY, PAUSE_KEY, RETRANS_KEY;
  - the state enum tx_ctrl_state_t {NORMAL, PAUSE, RETRANS}.
- One sub-module: frame_burst_counter, a saturating counter with clear, increment enable (frame_req) and terminal-count flag. It is instantiated for the burst counter and the gap counter.

Test Plan:
1. Reset, then tx_up = 1, data_avail = 1, 5 frame_req → code = {01, 16'h0000} with data_en = 1 on all 5 frames.
2. local_retrans pulse → exactly 12 frames of {10, 16'h1000}. Then ≥20 regular frames. A second pulse during that gap delays the next burst until gap frame 20.
3. local_pause held for 30 frames → 30 PAUSE frames. A 3-frame pulse → exactly 12 PAUSE frames, then NORMAL.
4. retrans_req rises → replay_rewind = 1 for exactly one cycle, data_en = 0 (IDLE) while high. After it falls, the next frame is data.
5. pause_req high with data_avail = 1 → IDLE frames only, data_en = 0. local_pause still produces PAUSE frames.
6. tx_up dropped mid RETRANS burst (frame 5) → next cycle code = IDLE, data_en = 0. After tx_up returns, no residual burst and no retrans_pending.
